// File: rtl/fifo_stream_reader.sv
// Turns a first-word-fall-through FIFO read port into a valid/ready stream.
// The stream outputs are registered, and m_tlast marks the last beat of each pkt_len-beat packet.
module fifo_stream_reader #(
  parameter int DWIDTH    = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [DWIDTH-1:0]    fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic                 fifo_rd_en,
  output logic [DWIDTH-1:0]    m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic                 busy,
  output logic [31:0]          pkts_sent
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DWIDTH-1:0]     skid_data;
  logic                  skid_last;
  logic                  skid_valid;
  logic [LEN_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
  logic [LEN_WIDTH-1:0]  len_q, eff_len;
  logic                  first_beat, pop_last, out_free, handshake;

  // A zero length is treated as single-beat packets; len_q only moves on a packet's first pop.
  assign first_beat = (beat_cnt == '0);
  assign eff_len    = first_beat ? ((pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len) : len_q;
  assign pop_last   = (beat_cnt == eff_len - LEN_WIDTH'(1));

  // Popping only while the skid is empty guarantees room without looking at m_tready.
  assign fifo_rd_en = ((state == RUN) || (state == DRAIN)) && !fifo_rd_empty && !skid_valid;
  assign handshake  = m_tvalid && m_tready;
  assign out_free   = !m_tvalid || m_tready;
  assign busy       = (state != IDLE) || m_tvalid;

  assign beat_cnt_nxt = !fifo_rd_en ? beat_cnt
                      : pop_last    ? '0
                      :               beat_cnt + LEN_WIDTH'(1);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (enable) state_nxt = RUN;
      RUN:   if (!enable) state_nxt = (beat_cnt_nxt == '0) ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)                      state_nxt = RUN;
        else if (fifo_rd_en && pop_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      len_q      <= '0;
      pkts_sent  <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (fifo_rd_en && first_beat) len_q <= eff_len;
      if (handshake && m_tlast) pkts_sent <= pkts_sent + 32'd1;

      if (fifo_rd_en) begin
        if (out_free) begin
          m_tdata  <= fifo_rd_data;
          m_tlast  <= pop_last;
          m_tvalid <= 1'b1;
        end else begin
          skid_last  <= pop_last;
          skid_valid <= 1'b1;
        end
      end else if (handshake) begin
        if (skid_valid) begin
          m_tdata    <= skid_data;
          m_tlast    <= skid_last;
          skid_valid <= 1'b0;
        end else begin
          m_tvalid <= 1'b0;
        end
      end
    end
  end

  // NOTE: skid payload needs no reset; skid_valid qualifies it.
  always_ff @(posedge clk) begin
    if (fifo_rd_en && !out_free) skid_data <= fifo_rd_data;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds it, and a packet-level scoreboard
// checks every delivered beat, the tlast framing, pkts_sent and the buffering bounds.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] pkt_len = 16'd4;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic          busy;
  logic [31:0]   pkts_sent;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DWIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pkt_len(pkt_len),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .pkts_sent(pkts_sent)
  );

  // First-word-fall-through FIFO model
  logic [DW-1:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_flush = 1'b0;
  assign fifo_rd_empty = (wr_ptr == rd_ptr);
  assign fifo_rd_data  = mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (fifo_flush)      rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_pop, n_del, m_cnt, m_len;
  logic [31:0] exp_pkts;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    n_pop = 0; n_del = 0; m_cnt = 0; m_len = 1; exp_pkts = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int target);
    int c = 0;
    while (n_del < target && c < 300) begin tick(); c++; end
    chk("deliver_timeout", 64'(n_del >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    enable = 1'b0;
    while (busy && c < 300) begin tick(); c++; end
    chk("idle_timeout", 64'(busy), 64'd0);
    chk("all_delivered", 64'(n_del), 64'(n_pop));
  endtask

  // Scoreboard: each popped word must come out once, in order, with tlast on every packet boundary.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int buffered = n_pop - n_del;
      beat_t b;
      chk("tvalid_tracks_buffer", 64'(m_tvalid), 64'(buffered > 0));
      chk("buffer_depth", 64'(buffered <= 2), 64'd1);
      if (buffered == 2) chk("no_pop_skid_full", 64'(fifo_rd_en), 64'd0);
      chk("pkts_sent", 64'(pkts_sent), 64'(exp_pkts));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(b.data));
          chk("beat_last", 64'(m_tlast), 64'(b.last));
          if (b.last) exp_pkts++;
        end
        n_del++;
      end
      if (fifo_rd_en) begin
        if (m_cnt == 0) m_len = (pkt_len == 0) ? 1 : int'(pkt_len);
        m_cnt++;
        b.data = fifo_rd_data;
        b.last = (m_cnt == m_len);
        if (b.last) m_cnt = 0;
        exp_q.push_back(b);
        n_pop++;
      end
    end
  end

  initial begin
    int c;
    int base_pop, base_del;
    logic [31:0] base_pkts;
    model_clear();

    // Reset state
    #3;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    // Streaming at full rate, pkt_len=4
    pkt_len = 4; m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) push(i);
    base_pkts = pkts_sent; base_del = n_del;
    tick();
    enable = 1'b1;
    c = 0;
    while (!fifo_rd_en && c < 10) begin tick(); c++; end
    chk("t1_pop_start", 64'(fifo_rd_en), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_pop_burst", 64'(fifo_rd_en), 64'd1);
      tick();
    end
    chk("t1_pop_stop", 64'(fifo_rd_en), 64'd0);
    wait_deliv(base_del + 8);
    chk("t1_pkts", 64'(pkts_sent - base_pkts), 64'd2);
    wait_idle();

    // Alternating backpressure
    for (int i = 1; i <= 8; i++) push(100 + i);
    base_pkts = pkts_sent; base_del = n_del;
    enable = 1'b1;
    c = 0;
    while (n_del < base_del + 8 && c < 100) begin m_tready = ~m_tready; tick(); c++; end
    chk("t2_delivered", 64'(n_del - base_del), 64'd8);
    chk("t2_pkts", 64'(pkts_sent - base_pkts), 64'd2);
    m_tready = 1'b1;
    wait_idle();

    // Enable dropped mid-packet: the packet completes, then the reader stops
    pkt_len = 5;
    for (int i = 1; i <= 10; i++) push(i);
    base_pop = n_pop;
    enable = 1'b1;
    c = 0;
    while (n_pop < base_pop + 2 && c < 20) begin tick(); c++; end
    wait_idle();
    chk("t3_pops", 64'(n_pop - base_pop), 64'd5);
    chk("t3_fifo_level", 64'(wr_ptr - rd_ptr), 64'd5);
    chk("t3_fifo_head", 64'(fifo_rd_data), 64'd6);
    enable = 1'b1;
    wait_deliv(n_pop + 5);
    wait_idle();
    chk("t3_fifo_empty", 64'(fifo_rd_empty), 64'd1);

    // pkt_len=0 means single-beat packets
    pkt_len = 0;
    for (int i = 1; i <= 3; i++) push(200 + i);
    base_pkts = pkts_sent; base_del = n_del;
    enable = 1'b1;
    wait_deliv(base_del + 3);
    chk("t4_len0_pkts", 64'(pkts_sent - base_pkts), 64'd3);
    wait_idle();

    // pkt_len change mid-packet is ignored until the next packet
    pkt_len = 3;
    for (int i = 1; i <= 10; i++) push(300 + i);
    base_pkts = pkts_sent; base_del = n_del; base_pop = n_pop;
    enable = 1'b1;
    c = 0;
    while (n_pop < base_pop + 1 && c < 20) begin tick(); c++; end
    pkt_len = 7;
    wait_deliv(base_del + 10);
    chk("t4_len_change_pkts", 64'(pkts_sent - base_pkts), 64'd2);
    wait_idle();

    // FIFO runs empty mid-packet
    pkt_len = 4;
    push(401); push(402);
    base_pkts = pkts_sent; base_del = n_del;
    enable = 1'b1;
    wait_deliv(base_del + 2);
    for (int i = 0; i < 5; i++) begin
      chk("t5_gap_busy", 64'(busy), 64'd1);
      chk("t5_gap_tvalid", 64'(m_tvalid), 64'd0);
      tick();
    end
    push(403); push(404);
    wait_deliv(base_del + 4);
    chk("t5_pkts", 64'(pkts_sent - base_pkts), 64'd1);
    wait_idle();

    // Random traffic, backpressure, enable and pkt_len
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) push($urandom);
      m_tready = ($urandom_range(3) != 0);
      if (i % 25 == 0) pkt_len = LW'($urandom_range(5));
      enable = ($urandom_range(15) != 0);
      tick();
    end
    enable = 1'b1; m_tready = 1'b1;
    c = 0;
    while ((!fifo_rd_empty || n_del != n_pop) && c < 300) begin tick(); c++; end
    chk("rand_drained", 64'(n_del), 64'(n_pop));
    for (int i = 0; i < 8; i++) push($urandom);
    wait_idle();
    fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;

    // Asynchronous reset with the skid entry full mid-packet
    pkt_len = 4; m_tready = 1'b0;
    for (int i = 1; i <= 6; i++) push(500 + i);
    enable = 1'b1;
    c = 0;
    while ((n_pop - n_del) < 2 && c < 20) begin tick(); c++; end
    chk("t6_skid_full", 64'(n_pop - n_del), 64'd2);
    tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_pkts", 64'(pkts_sent), 64'd0);
    chk("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    m_tready = 1'b1; pkt_len = 3;
    push(507); push(508);
    wait_deliv(6);
    chk("t6_post_rst_pkts", 64'(pkts_sent), 64'd2);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
